// File: rtl/tap_pkg.sv
// Shared constants and helpers for the tap conditioner slice.
package tap_pkg;

    // Channel count, fixed by the width of the tap bus that game_logic consumes.
    localparam int N_TAPS = 8;

    // 10 ms stable time at 100 MHz.
    localparam int DEBOUNCE_DEFAULT = 1_000_000;

    // Short stable time so simulations finish quickly.
    localparam int DEBOUNCE_SIM = 4;

    // Ceiling log2, used to size the debounce counter.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >>> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tap_debounce_ch.sv
// One button channel: 2-FF synchroniser, stable-time debounce counter,
// debounced level register and a combinational rise flag that marks the
// edge on which the debounced level is about to go 0->1.
module tap_debounce_ch
    import tap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic held,
    output logic rise
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The new level has been stable for the full interval on this edge.
    assign accept = (s2 != held) && (cnt == CNT_MAX);
    assign rise   = accept && s2;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Count consecutive cycles at the new level; any return to the old level
    // restarts the interval, and acceptance clears the counter so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= 1'b0;
            cnt  <= '0;
        end else if (s2 == held) begin
            cnt <= '0;
        end else if (accept) begin
            held <= s2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tap_conditioner.sv
// Turns the raw mole-hole buttons into clean one-cycle tap pulses for
// game_logic. Taps are gated by the start level and registered.
// Optional build macro TAP_PRIORITY_EN: when defined, tap is at most one-hot
// and the lowest qualifying channel wins; the other channels' presses are
// dropped. When undefined, every qualifying channel pulses together.
module tap_conditioner
    import tap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_TAPS-1:0] btn_raw,
    input  logic              start,
    output logic [N_TAPS-1:0] tap,
    output logic [N_TAPS-1:0] held
);

    logic [N_TAPS-1:0] rise;
    logic [N_TAPS-1:0] qual;
    logic [N_TAPS-1:0] tap_next;

    for (genvar i = 0; i < N_TAPS; i++) begin : g_ch
        tap_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[i]),
            .held   (held[i]),
            .rise   (rise[i])
        );
    end

    // Presses outside a running round are dropped, never queued.
    assign qual = start ? rise : '0;

`ifdef TAP_PRIORITY_EN
    // Isolate the lowest set bit so only one hole can score per cycle.
    assign tap_next = qual & (~qual + 1'b1);
`else
    assign tap_next = qual;
`endif

    // Register the strike pulses so game_logic sees a clean one-cycle tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap <= '0;
        end else begin
            tap <= tap_next;
        end
    end

endmodule

// File: tb/tb_tap_conditioner.sv
// Directed bench for tap_conditioner with a 4-cycle debounce interval.
module tb_tap_conditioner;
    import tap_pkg::*;

    logic              clk;
    logic              rst;
    logic [N_TAPS-1:0] btn_raw;
    logic              start;
    logic [N_TAPS-1:0] tap;
    logic [N_TAPS-1:0] held;

    int total;
    int bad;

    tap_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_SIM)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .start  (start),
        .tap    (tap),
        .held   (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release every button and confirm the release produces no tap.
    task automatic release_all(input string tag);
        btn_raw = 8'h00;
        for (int k = 0; k < 8; k++) begin
            step();
            check_val(tag, tap, 8'h00);
        end
        check_val({tag, "_held"}, held, 8'h00);
    endtask

    // Drive a press, expect nothing for 5 edges, then the tap on the 6th edge only.
    task automatic press_expect(input string tag, input logic [7:0] btn, input logic [7:0] exp_tap);
        btn_raw = btn;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val({tag, "_pre"}, tap, 8'h00);
        end
        step();
        check_val({tag, "_tap"}, tap, exp_tap);
        check_val({tag, "_held"}, held, btn);
        step();
        check_val({tag, "_post"}, tap, 8'h00);
        check_val({tag, "_held2"}, held, btn);
    endtask

    initial begin
        logic [7:0] exp_sim;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        btn_raw = 8'hFF;
        start   = 1'b0;

        // Reset held for three cycles with every button pressed.
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("rst_tap", tap, 8'h00);
            check_val("rst_held", held, 8'h00);
        end
        rst     = 1'b0;
        btn_raw = 8'h00;
        for (int k = 0; k < 4; k++) step();
        check_val("idle_held", held, 8'h00);

        // Clean press on channel 3.
        start = 1'b1;
        press_expect("clean", 8'h08, 8'h08);
        release_all("clean_rel");

        // Bounce on channel 0: high 3, low 1, then high.
        btn_raw = 8'h01;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("bounce_hi", tap, 8'h00);
        end
        btn_raw = 8'h00;
        step();
        check_val("bounce_lo", tap, 8'h00);
        press_expect("bounce", 8'h01, 8'h01);
        release_all("bounce_rel");

        // Gate: press while stopped, then start while still held.
        start   = 1'b0;
        btn_raw = 8'h04;
        for (int k = 0; k < 6; k++) begin
            step();
            check_val("gate_tap", tap, 8'h00);
        end
        check_val("gate_held", held, 8'h04);
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("gate_start", tap, 8'h00);
        end
        release_all("gate_rel");

        // Simultaneous press on channels 1 and 5.
`ifdef TAP_PRIORITY_EN
        exp_sim = 8'h02;
`else
        exp_sim = 8'h22;
`endif
        press_expect("simul", 8'h22, exp_sim);
        release_all("simul_rel");

        // Mid-count reset on channel 7, then a fresh press after reset.
        btn_raw = 8'h80;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("midrst_pre", tap, 8'h00);
        end
        rst = 1'b1;
        step();
        check_val("midrst_tap", tap, 8'h00);
        check_val("midrst_held", held, 8'h00);
        rst = 1'b0;
        press_expect("midrst", 8'h80, 8'h80);
        release_all("midrst_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/tap_conditioner.md
# tap_conditioner

Input-conditioning stage directly upstream of `game_logic`: turns the eight raw, asynchronous, bouncing mole-hole buttons into the clean `tap[7:0]` one-cycle strike pulses that `game_logic` scores. Each channel is synchronised, debounced by a stable-time counter, and rising-edge detected. Taps are gated by the game-running `start` level so presses outside a round never reach scoring.

## Interface
- `N_TAPS`, 8: number of button channels; fixed by the `tap` width consumed by `game_logic`.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a new level must stay stable before it is accepted (10 ms at 100 MHz); legal range ≥ 2.
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `btn_raw`  in  N_TAPS: raw button levels, asynchronous to `clk`, active-high.
- `start`  in  1: game running; taps are emitted only while high.
- `tap`  out  N_TAPS: one-cycle strike pulse per channel, registered.
- `held`  out  N_TAPS: debounced button level per channel, registered.

## Operation
- Per channel: 2-FF synchroniser (`s1`, `s2`), debounced level `held[i]`, counter `cnt[i]` of width clog2(DEBOUNCE_CYCLES).
- Per clock edge, per channel:
  - `s2 == held`: `cnt` cleared.
  - `s2 != held` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` += 1.
  - `s2 != held` and `cnt == DEBOUNCE_CYCLES-1`: `held` takes `s2`, `cnt` cleared.
- Any single-cycle return to the old level clears `cnt`; the full stable interval restarts.
- `tap[i]` is high for exactly the one cycle after `held[i]` goes 0→1, and only if `start` is high on that edge. Release (1→0) never produces a tap.
- `start` low: `held` keeps tracking; `tap` forced 0. Pulses are dropped, not queued. `start` rising while `held[i]` = 1 does not produce a tap.
- Channels are independent. Several channels qualifying on the same edge all assert in the same cycle; see Configuration.
- Counter never wraps: saturation is impossible because it clears on acceptance.

## Timing
- Reset values: `s1`, `s2`, `held`, `cnt`, `tap` all 0.
- Latency: when `btn_raw[i]` settles at a new level before edge 0, `s2` shows it after edge 1. `held[i]` and `tap[i]` change after edge 1+DEBOUNCE_CYCLES, and are visible in cycle 2+DEBOUNCE_CYCLES.
- `tap` is a pure registered output, so `game_logic` samples it one cycle wide.
- `rst` during counting: everything clears, no tap. A button still pressed when `rst` drops is treated as a fresh press: `tap` fires 2+DEBOUNCE_CYCLES cycles later if `start` is high.
- `rst` has priority over all other activity on the same edge.

## Configuration
- `TAP_PRIORITY_EN` defined: `tap` is guaranteed at most one-hot. If several channels qualify on the same edge, only the lowest index is emitted and the others are dropped for that press. `held` is unaffected.
- Not defined: every qualifying channel asserts its `tap` bit in the same cycle.

## Structure
- Shared package `tap_pkg`:
  - `N_TAPS` constant.
  - Default `DEBOUNCE_CYCLES`.
  - `clog2` function for counter sizing.
  - A simulation value `DEBOUNCE_SIM` = 4.
- One sub-module is natural: `tap_debounce_ch`, a single channel containing the synchroniser, counter, `held` register and rise flag. It is instantiated N_TAPS times by a generate loop.
- The top level holds the `start` gate, the optional priority encoder and the `tap` output register.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: assert `rst` 3 cycles with `btn_raw` = 8'hFF → `tap` = 0 and `held` = 0 throughout reset.
- Clean press: `start` = 1; `btn_raw[3]` rises and holds → `tap` = 8'h08 for exactly one cycle, in cycle 6 after the change; `held[3]` = 1 from then on; release gives no tap.
- Bounce: `btn_raw[0]` high 3 cycles, low 1 cycle, then high → no tap during the bounce; single `tap` = 8'h01 exactly 6 cycles after the final rise.
- Gate: `start` = 0; press `btn_raw[2]` → `held[2]` rises, `tap` stays 0. Raising `start` while still held → still no tap.
- Simultaneous: press `btn_raw[1]` and `btn_raw[5]` on the same cycle with `start` = 1 → `tap` = 8'h22 without `TAP_PRIORITY_EN`, 8'h02 with it.
- Mid-count reset: press `btn_raw[7]`; pulse `rst` at count 2 → no tap, `cnt` cleared. After `rst` drops with the button still pressed → `tap` = 8'h80 six cycles later.
